// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared AXI types, constants and read-master state encoding
package utils_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_USER_W = 1;

  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam logic [1:0] AXI_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_ID_W-1:0]   axi_id_t;

  typedef struct packed {
    axi_id_t               awid;
    axi_addr_t             awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [AXI_USER_W-1:0] awuser;
    logic                  awvalid;
    axi_data_t             wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic [AXI_USER_W-1:0] wuser;
    logic                  wvalid;
    logic                  bready;
    axi_id_t               arid;
    axi_addr_t             araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic [AXI_USER_W-1:0] aruser;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    axi_id_t               bid;
    logic [1:0]            bresp;
    logic [AXI_USER_W-1:0] buser;
    logic                  bvalid;
    logic                  arready;
    axi_id_t               rid;
    axi_data_t             rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;

  typedef struct packed {
    axi_addr_t   addr;
    logic [15:0] words;
  } axi_rd_cmd_t;

  typedef enum logic [1:0] {IDLE, AR, R, DONE} eth_rd_mst_st_t;

endpackage

// File: rtl/eth_axi_rd_master_skid.sv
// rtl/eth_axi_rd_master_skid.sv - eth_rd_skid: 1-deep registered output stage with valid/ready
module eth_rd_skid
  import utils_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  axi_data_t s_tdata,
  input  logic      s_tlast,
  input  logic      s_tvalid,
  output logic      s_tready,
  output axi_data_t m_tdata,
  output logic      m_tlast,
  output logic      m_tvalid,
  input  logic      m_tready
);

  // Accept a new word whenever the register is empty or is being drained this cycle
  assign s_tready = m_tready || !m_tvalid;

  // Output register: only loads on acceptance, so it holds steady while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      m_tlast  <= s_tvalid && s_tlast;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
      end
    end
  end

endmodule

// File: rtl/eth_axi_rd_master.sv
// rtl/eth_axi_rd_master.sv - AXI4 read initiator splitting word commands into 4 KiB-safe INCR bursts
module eth_axi_rd_master
  import utils_pkg::*;
#(
  parameter int      MAX_BURST = 16,
  parameter int      CNT_W     = 16,
  parameter axi_id_t TXN_ID    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  axi_addr_t        cmd_addr_i,
  input  logic [CNT_W-1:0] cmd_words_i,
  output s_axi_mosi_t      axi_mosi_o,
  input  s_axi_miso_t      axi_miso_i,
  output axi_data_t        rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_last_o,
  input  logic             rd_ready_i,
  output logic             done_o,
  output logic             err_o
);

  eth_rd_mst_st_t   state_q, state_d;
  axi_addr_t        addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [8:0]       beats_q, beats_d;
  logic [8:0]       bcnt_q, bcnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [12:0]      page_bytes;
  logic [31:0]      beats_w;
  logic [8:0]       burst_beats;
  logic             skid_valid, skid_ready, skid_last;
  logic             r_hs;
  logic             unused_bits;

  // Burst size: smallest of remaining words, MAX_BURST and words left in the 4 KiB page
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    beats_w    = 32'(MAX_BURST);
    if (32'(rem_q) < beats_w) beats_w = 32'(rem_q);
    if (32'(page_bytes[12:2]) < beats_w) beats_w = 32'(page_bytes[12:2]);
    burst_beats = beats_w[8:0];
  end

  // Final word of the command: last beat of a burst with nothing left to request
  assign skid_last = axi_miso_i.rlast && (rem_q == '0);

  // Next-state, datapath updates and AXI request outputs
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    bcnt_d      = bcnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cmd_ready_o = 1'b0;
    skid_valid  = 1'b0;
    r_hs        = 1'b0;
    axi_mosi_o         = '0;
    axi_mosi_o.bready  = 1'b1;
    axi_mosi_o.arid    = TXN_ID;
    axi_mosi_o.araddr  = addr_q;
    axi_mosi_o.arlen   = 8'(burst_beats - 9'd1);
    axi_mosi_o.arsize  = AXI_SIZE_4B;
    axi_mosi_o.arburst = AXI_INCR;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_words_i;
          err_d   = 1'b0;
          state_d = (cmd_words_i == '0) ? DONE : AR;
        end
      end
      AR: begin
        axi_mosi_o.arvalid = 1'b1;
        if (axi_miso_i.arready) begin
          addr_d  = addr_q + AXI_ADDR_W'({burst_beats, 2'b00});
          rem_d   = rem_q - CNT_W'(burst_beats);
          beats_d = burst_beats;
          bcnt_d  = '0;
          state_d = R;
        end
      end
      R: begin
        axi_mosi_o.rready = skid_ready;
        skid_valid        = axi_miso_i.rvalid;
        r_hs              = axi_miso_i.rvalid && skid_ready;
        if (r_hs) begin
          bcnt_d = bcnt_q + 9'd1;
          if (axi_miso_i.rresp != AXI_OKAY || axi_miso_i.rid != TXN_ID) err_d = 1'b1;
          if (axi_miso_i.rlast) begin
            // early rlast is flagged but still ends the burst
            if (bcnt_q != beats_q - 9'd1) err_d = 1'b1;
            state_d = (rem_q != '0) ? AR : DONE;
          end else if (bcnt_q == beats_q - 9'd1) begin
            // missing rlast: keep accepting until the slave ends the burst
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!rd_valid_o || rd_ready_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

  eth_rd_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (axi_miso_i.rdata),
    .s_tlast  (skid_last),
    .s_tvalid (skid_valid),
    .s_tready (skid_ready),
    .m_tdata  (rd_data_o),
    .m_tlast  (rd_last_o),
    .m_tvalid (rd_valid_o),
    .m_tready (rd_ready_i)
  );

  assign unused_bits = ^{page_bytes[1:0], beats_w[31:9], axi_miso_i.awready, axi_miso_i.wready,
                         axi_miso_i.bid, axi_miso_i.bresp, axi_miso_i.buser, axi_miso_i.bvalid,
                         axi_miso_i.ruser};

endmodule

// File: tb/tb_eth_axi_rd_master.sv
// tb/tb_eth_axi_rd_master.sv - randomized self-checking bench for eth_axi_rd_master
module tb_eth_axi_rd_master;
  import utils_pkg::*;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  axi_addr_t   cmd_addr = '0;
  logic [15:0] cmd_words = '0;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso = '0;
  axi_data_t   rd_data;
  logic        rd_valid, rd_last, done, err;
  logic        rd_ready = 1'b1;

  always #5 clk = ~clk;

  eth_axi_rd_master #(.MAX_BURST(MAXB), .CNT_W(16), .TXN_ID('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_words_i (cmd_words),
    .axi_mosi_o  (mosi),
    .axi_miso_i  (miso),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_last_o   (rd_last),
    .rd_ready_i  (rd_ready),
    .done_o      (done),
    .err_o       (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic axi_data_t pat(input axi_addr_t a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // slave / consumer knobs
  bit ar_cont = 1'b1, r_cont = 1'b1, err_rid = 1'b0;
  int rdy_mode = 0, err_beat = -1, gbeat = 0, cyc = 0;

  // slave state and handshake flags
  bit        b_act = 1'b0, hs_ar = 1'b0, hs_r = 1'b0, hs_out = 1'b0;
  axi_addr_t b_addr, ar_addr_s;
  int        b_len, b_beat, ar_len_s;

  // observations
  axi_addr_t obs_ar_addr[$];
  int        obs_ar_len[$];
  axi_data_t obs_data[$];
  bit        obs_last[$];
  int        stall_viol, rready_viol, ar_field_bad, arv_cycles;
  bit        prev_stall = 1'b0, prev_last;
  axi_data_t prev_data;

  // expected bursts
  axi_addr_t exp_addr[$];
  int        exp_len[$];

  // AXI slave, consumer and monitor: drive at negedge, sample handshakes just after
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      b_act = 1'b0; hs_ar = 1'b0; hs_r = 1'b0; hs_out = 1'b0; prev_stall = 1'b0;
      miso = '0;
      rd_ready = 1'b1;
    end else begin
      if (hs_ar) begin
        b_act = 1'b1; b_addr = ar_addr_s; b_len = ar_len_s; b_beat = 0;
      end
      if (hs_r) begin
        b_beat++; gbeat++;
        if (b_beat > b_len) b_act = 1'b0;
      end
      miso.arready = !b_act && (ar_cont || $urandom_range(0, 1) == 1);
      if (!(miso.rvalid && !hs_r)) begin
        miso.rvalid = b_act && (r_cont || $urandom_range(0, 3) != 0);
        miso.rdata  = pat(b_addr + 32'(b_beat * 4));
        miso.rlast  = (b_beat == b_len);
        miso.rresp  = (gbeat == err_beat && !err_rid) ? 2'b10 : 2'b00;
        miso.rid    = (gbeat == err_beat && err_rid) ? 4'd1 : 4'd0;
      end
      case (rdy_mode)
        1:       rd_ready = cyc[0];
        2:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = 1'b1;
      endcase
    end
    #1;
    if (rst) begin
      hs_ar = mosi.arvalid && miso.arready;
      if (mosi.arvalid) arv_cycles++;
      if (hs_ar) begin
        ar_addr_s = mosi.araddr; ar_len_s = int'(mosi.arlen);
        obs_ar_addr.push_back(mosi.araddr); obs_ar_len.push_back(int'(mosi.arlen));
        if (mosi.arsize != 3'd2 || mosi.arburst != 2'd1 || mosi.arid != 4'd0) ar_field_bad++;
      end
      hs_r   = miso.rvalid && mosi.rready;
      hs_out = rd_valid && rd_ready;
      if (hs_out) begin
        obs_data.push_back(rd_data); obs_last.push_back(rd_last);
      end
      if (prev_stall && (!rd_valid || rd_data != prev_data || rd_last != prev_last)) stall_viol++;
      if (rd_valid && !rd_ready && mosi.rready) rready_viol++;
      prev_stall = rd_valid && !rd_ready; prev_data = rd_data; prev_last = rd_last;
    end
  end

  // Reference burst plan: split by remaining words, MAXB and 4 KiB page room
  task automatic expect_bursts(input axi_addr_t a, input int w);
    int room, b;
    exp_addr.delete(); exp_len.delete();
    while (w > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = w;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_addr.push_back(a); exp_len.push_back(b - 1);
      a = a + 32'(b * 4);
      w = w - b;
    end
  endtask

  task automatic setup(input int eb, input bit erid, input bit arc, input bit rc, input int rm);
    ar_cont = arc; r_cont = rc; rdy_mode = rm; err_beat = eb; err_rid = erid; gbeat = 0;
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_data.delete(); obs_last.delete();
    stall_viol = 0; rready_viol = 0; ar_field_bad = 0; arv_cycles = 0;
  endtask

  task automatic issue_cmd(input axi_addr_t a, input int w);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_addr = a; cmd_words = 16'(w); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input axi_addr_t a, input int w, input int eb, input bit erid,
                         input bit arc, input bit rc, input int rm);
    int n;
    bit exp_err;
    setup(eb, erid, arc, rc, rm);
    expect_bursts(a, w);
    issue_cmd(a, w);
    check("err_clear_on_accept", err, 0);
    if (w > 0) check("ar_latency", mosi.arvalid, 1);
    n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
    if (w == 0) begin
      check("zero_done_latency", n, 1);
      check("zero_no_arvalid", arv_cycles, 0);
    end
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("ar_count", obs_ar_addr.size(), exp_addr.size());
    for (int i = 0; i < obs_ar_addr.size() && i < exp_addr.size(); i++) begin
      check("ar_addr", obs_ar_addr[i], exp_addr[i]);
      check("ar_len", obs_ar_len[i], exp_len[i]);
    end
    check("word_count", obs_data.size(), w);
    for (int k = 0; k < obs_data.size() && k < w; k++) begin
      check("word_data", obs_data[k], pat(a + 32'(k * 4)));
      check("word_last", obs_last[k], (k == w - 1));
    end
    check("ar_fields", ar_field_bad, 0);
    check("stall_stable", stall_viol, 0);
    check("rready_when_full", rready_viol, 0);
    exp_err = (eb >= 0) && (eb < w);
    check("err_sticky", err, exp_err);
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_arvalid"}, mosi.arvalid, 0);
    check({tag, "_rready"}, mosi.rready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    axi_addr_t ra;
    int rw, re, n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    run_cmd(32'h0000_1000, 8, -1, 1'b0, 1'b1, 1'b1, 0);
    run_cmd(32'h0000_0000, 40, -1, 1'b0, 1'b1, 1'b1, 0);
    run_cmd(32'h0000_0FF8, 8, -1, 1'b0, 1'b1, 1'b1, 0);
    run_cmd(32'h0000_2000, 20, -1, 1'b0, 1'b1, 1'b1, 1);
    run_cmd(32'h0000_3000, 4, 2, 1'b0, 1'b1, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("err_held_in_idle", err, 1);
    run_cmd(32'h0000_0100, 0, -1, 1'b0, 1'b1, 1'b1, 0);
    run_cmd(32'h0000_7FF0, 24, 5, 1'b1, 1'b0, 1'b0, 2);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFC0 + 12'($urandom_range(0, 15) * 4);
      rw = $urandom_range(0, 60);
      re = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
      run_cmd(ra, rw, re, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // reset in the middle of a 16-beat burst carrying an error
    setup(1, 1'b0, 1'b1, 1'b1, 0);
    issue_cmd(32'h0000_4000, 16);
    n = 0;
    while (obs_data.size() < 3 && n < 200) begin @(negedge clk); n++; end
    check("rst_mid_burst_reached", obs_data.size() >= 3, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    run_cmd(32'h0000_5000, 12, -1, 1'b0, 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
